// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC, IF/ID register, BOOT/RUN/HALT control
// Optional fetch/stall statistics counters enabled by defining IF_STAT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        halted
`ifdef IF_STAT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;
    logic [31:0] reset_pc_aligned;
    logic        hit_halt;
    logic        do_fetch;
    logic        unused_target_lsbs;

    assign pc_plus4           = pc + 32'd4;
    assign target_aligned     = {branch_target[31:2], 2'b00};
    assign reset_pc_aligned   = {RESET_PC[31:2], 2'b00};
    assign unused_target_lsbs = ^branch_target[1:0];
    assign hit_halt           = (imem_rdata == HALT_WORD);
    assign do_fetch           = (state == ST_RUN) && !branch_taken && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (do_fetch && hit_halt) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (branch_taken) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    // Memory-side outputs depend only on registered state and stall, never on imem_rdata.
    always_comb begin
        imem_addr = pc;
        imem_en   = (state == ST_RUN) && !stall;
        halted    = (state == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= reset_pc_aligned;
            ifid_pc4   <= 32'd0;
            ifid_instr <= 32'd0;
            ifid_valid <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (branch_taken) begin
                        pc         <= target_aligned;
                        ifid_pc4   <= 32'd0;
                        ifid_instr <= 32'd0;
                        ifid_valid <= 1'b0;
                    end else if (!stall) begin
                        if (hit_halt) begin
                            // The halt word is never passed to decode; pc stays on it.
                            ifid_pc4   <= 32'd0;
                            ifid_instr <= 32'd0;
                            ifid_valid <= 1'b0;
                        end else begin
                            pc         <= pc_plus4;
                            ifid_pc4   <= pc_plus4;
                            ifid_instr <= imem_rdata;
                            ifid_valid <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (branch_taken) begin
                        pc <= target_aligned;
                    end
                    ifid_pc4   <= 32'd0;
                    ifid_instr <= 32'd0;
                    ifid_valid <= 1'b0;
                end
                default: begin
                    pc         <= reset_pc_aligned;
                    ifid_pc4   <= 32'd0;
                    ifid_instr <= 32'd0;
                    ifid_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (do_fetch && !hit_halt) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if ((state == ST_RUN) && stall && !branch_taken) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage (vector table + scoreboard)
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        halted;
`ifdef IF_STAT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    logic [31:0] halt_addr;
    int          n_total;
    int          n_pass;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_rdata   (imem_rdata),
        .ifid_pc4     (ifid_pc4),
        .ifid_instr   (ifid_instr),
        .ifid_valid   (ifid_valid),
        .halted       (halted)
`ifdef IF_STAT_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: every word is its address plus 0x100, except the halt sentinel.
    always_comb begin
        imem_rdata = (imem_addr == halt_addr) ? 32'hFFFF_FFFF : imem_addr + 32'h100;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        chk_en;
        logic        en;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [31:0] t,
                                input logic ce, input logic e, input logic [31:0] p,
                                input logic [31:0] p4, input logic [31:0] ins, input logic v,
                                input logic h);
        vec_t x;
        x.rst = r; x.stall = s; x.br = b; x.tgt = t; x.chk_en = ce; x.en = e;
        x.pc = p; x.pc4 = p4; x.instr = ins; x.valid = v; x.halted = h;
        return x;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic step(input int idx, input vec_t v);
        vec_t e;
        sb.push_back(v);
        rst           = v.rst;
        stall         = v.stall;
        branch_taken  = v.br;
        branch_target = v.tgt;
        #1;
        if (v.chk_en) check("imem_en", idx, {31'd0, imem_en}, {31'd0, v.en});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("imem_addr", idx, imem_addr, e.pc);
        check("ifid_pc4", idx, ifid_pc4, e.pc4);
        check("ifid_instr", idx, ifid_instr, e.instr);
        check("ifid_valid", idx, {31'd0, ifid_valid}, {31'd0, e.valid});
        check("halted", idx, {31'd0, halted}, {31'd0, e.halted});
    endtask

    initial begin
        n_total       = 0;
        n_pass        = 0;
        halt_addr     = 32'h20;
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;

        //                 rst  stl  br   tgt           ce   en   pc            pc4           instr         v    h
        vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h4,        32'h4,        32'h100,      1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h8,        32'h8,        32'h104,      1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'hC,        32'hC,        32'h108,      1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h10,       32'h10,       32'h10C,      1'b1,1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,    1'b1,1'b0,32'h10,       32'h10,       32'h10C,      1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h14,       32'h14,       32'h110,      1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,32'h43,       1'b1,1'b0,32'h40,       32'h0,        32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h44,       32'h44,       32'h140,      1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h1E,       1'b1,1'b1,32'h1C,       32'h0,        32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h20,       32'h20,       32'h11C,      1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h20,       32'h0,        32'h0,        1'b0,1'b1));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1'b0,i[0],1'b0,32'h0,    1'b1,1'b0,32'h20,       32'h0,        32'h0,        1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'hFFFF_FFFC,1'b1,1'b0,32'hFFFF_FFFC,32'h0,        32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0,        32'h0,        32'hFC,       1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h4,        32'h4,        32'h100,      1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h20,       1'b1,1'b1,32'h20,       32'h0,        32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h20,       32'h0,        32'h0,        1'b0,1'b1));
        vecs.push_back(mk(1'b1,1'b1,1'b1,32'h80,       1'b1,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h4,        32'h4,        32'h100,      1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i]);
`ifdef IF_STAT_EN
            if (i == 10) begin
                check("stall_cnt", i, stall_cnt, 32'd3);
                check("fetch_cnt", i, fetch_cnt, 32'd5);
            end
`endif
        end

        // Redirect to a misaligned target, then a straight run of back-to-back fetches.
        step(100, mk(1'b0,1'b0,1'b1,32'h201,1'b1,1'b1,32'h200,32'h0,32'h0,1'b0,1'b0));
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a;
            a = 32'h200 + 32'(k) * 32'd4;
            step(101 + k, mk(1'b0,1'b0,1'b0,32'h0,1'b1,1'b1,a + 32'd4,a + 32'd4,a + 32'h100,1'b1,1'b0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, instantiated inside `TongHop` between the instruction memory and the decode stage. It owns the program counter and the IF/ID pipeline register, and follows stall and redirect requests from the hazard/branch logic. A small control FSM provides a one-cycle boot after reset and a halt state that is entered when a sentinel instruction is fetched.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset; bits [1:0] must be 0.
- `HALT_WORD`, default `32'hFFFF_FFFF`: instruction encoding that stops fetch.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit request: hold the PC and IF/ID.
- `branch_taken`  in  1  redirect request from the resolved branch/jump.
- `branch_target`  in  32  redirect address; bits [1:0] are ignored.
- `imem_addr`  out  32  instruction memory address; equals `pc`.
- `imem_en`  out  1  fetch strobe.
- `imem_rdata`  in  32  instruction word; combinational read of `imem_addr`.
- `ifid_pc4`  out  32  PC+4 of the instruction held in IF/ID.
- `ifid_instr`  out  32  instruction held in IF/ID.
- `ifid_valid`  out  1  IF/ID holds a real instruction; 0 means bubble.
- `halted`  out  1  FSM is in HALT.

## Operation
- **PC and bubble rules**
  - `pc[1:0]` is always `2'b00`.
  - `pc + 4` wraps from `0xFFFF_FFFC` to `0x0000_0000`.
  - A bubble is `ifid_instr=0` (nop), `ifid_pc4=0`, `ifid_valid=0`.
- **FSM states: BOOT, RUN, HALT.** `rst` forces BOOT.
- **BOOT**
  - `pc` holds at `RESET_PC`.
  - IF/ID is a bubble.
  - `imem_en=0`.
  - Moves to RUN unconditionally after one cycle.
- **RUN.** Priority is `branch_taken` > `stall` > normal fetch.
  - `branch_taken`: `pc <= {branch_target[31:2],2'b00}`, IF/ID <= bubble, stay in RUN.
  - `stall` without a branch: `pc` and IF/ID hold, `imem_en=0`.
  - Normal fetch with `imem_rdata == HALT_WORD`: IF/ID <= bubble, `pc` holds, go to HALT. The halt word never enters IF/ID.
  - Normal fetch otherwise: IF/ID <= {`pc+4`, `imem_rdata`, 1} and `pc <= pc+4`.
  - `imem_en=1` whenever RUN and `!stall`.
- **HALT**
  - `imem_en=0`.
  - IF/ID stays a bubble.
  - `pc` holds.
  - `branch_taken` redirects `pc` to the target and returns to RUN. This covers an older in-flight branch that makes the halt word wrong-path.
  - `stall` has no effect in HALT.
- `halted = (state == HALT)`.

## Timing
- Reset values: `pc=RESET_PC`, `imem_addr=RESET_PC`, `imem_en=0`, `ifid_pc4=0`, `ifid_instr=0`, `ifid_valid=0`, `halted=0`, state BOOT.
- The first real instruction appears in IF/ID 2 edges after the first edge with `rst=0`:
  - edge 1 leaves BOOT;
  - edge 2 latches the word at `RESET_PC`.
- Fetch latency is 1 cycle, from `imem_addr` to IF/ID. Throughput is 1 instruction/cycle in RUN.
- `branch_taken` takes effect at the same edge it is sampled on. The instruction at the target is in IF/ID one edge later.
- `rst` asserted mid-operation overrides all other inputs at that edge, including in HALT and during a stall.
- `imem_addr`, `imem_en` and `halted` are functions of registered state plus `stall` only. There is no path from `imem_rdata` to `imem_addr`.

## Configuration
- `IF_STAT_EN` defined adds two outputs.
  - `fetch_cnt` (32): increments on each edge that loads a valid instruction into IF/ID.
  - `stall_cnt` (32): increments on each edge in RUN with `stall=1` and `branch_taken=0`.
  - Both counters are 0 on reset and wrap modulo 2^32.
- `IF_STAT_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- **Reset and boot.** `rst=1` for 2 cycles, then release; imem returns `addr+0x100`. Required:
  - `ifid_valid=0` for the first edge;
  - then `ifid_pc4=4`, `ifid_instr=0x100`;
  - then `ifid_pc4=8`, `ifid_instr=0x104`.
- **Stall.** Assert `stall` for 3 cycles while `pc=0x10`. Required:
  - `pc` and IF/ID frozen and `imem_en=0` for those cycles;
  - the fetch at `0x10` resumes on release;
  - with `IF_STAT_EN`, `stall_cnt=3`.
- **Branch over stall.** `branch_taken=1`, `stall=1`, `branch_target=0x43` in the same cycle. Required:
  - `pc=0x40` and IF/ID a bubble;
  - next edge `ifid_pc4=0x44`.
- **Halt.** imem returns `0xFFFF_FFFF` at `0x20`. Required:
  - `halted=1` one edge later, `pc=0x20`, IF/ID a bubble;
  - stays halted for 10 cycles with `imem_en=0`.
- **Halt exit and wrap.** Required:
  - In HALT, `branch_taken` with target `0xFFFF_FFFC` gives `halted=0`, then the next fetch gives `ifid_pc4=0x0000_0000` and `pc=0`.
  - `rst` asserted in HALT returns to BOOT with all outputs at their reset values.
